// File: rtl/uart_mem_loader_pkg.sv
// Shared definitions for the UART memory boot loader.
//  - state_t   : loader FSM encoding
//  - WE_*      : Memory write-enable codes used by the loader
//  - SYNC_BYTE_DEF : default frame start marker
package uart_mem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN0,
        ST_LEN1,
        ST_DATA,
        ST_CHK,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [1:0] WE_NONE = 2'b00;
    localparam logic [1:0] WE_WORD = 2'b01;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

endpackage

// File: rtl/uart_mem_loader_if.sv
// Memory write-port bundle (WE/ADDR/WD).
//  master : drives we/addr/wd (core side, or the loader's output towards Memory)
//  slave  : receives we/addr/wd
interface uart_mem_loader_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [1:0]            we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           wd;

    modport master (output we, addr, wd);
    modport slave  (input  we, addr, wd);
endinterface

// File: rtl/uart_mem_loader_timeout_ctr.sv
// Idle-cycle counter for the loader.
//  clk, rst_n : clock, asynchronous active-low reset
//  clear      : force the count back to zero (highest priority)
//  enable     : count one cycle when not cleared
//  expired    : count has reached TERMINAL; the count saturates there
module loader_timeout_ctr #(
    parameter int unsigned TERMINAL = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(TERMINAL + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expired = (cnt_q >= CW'(TERMINAL));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/uart_mem_loader.sv
// UART boot loader in front of the Memory write port.
// Frame: SYNC, LEN_LO, LEN_HI (word count N), 4*N payload bytes LSB first
// [, 8-bit sum of payload bytes when LOADER_CHECKSUM_EN is defined].
// Ports:
//  clk, rst_n          clock, asynchronous active-low reset
//  rx_data, rx_valid   received byte and its one-cycle strobe
//  core (slave)        core write port (we/addr/wd)
//  mem  (master)       Memory write port, muxed between loader and core
//  core_hold           1 = loader owns the Memory port, core held
//  load_done           last frame completed
//  load_error          last frame aborted (length, timeout, checksum)
// Optional feature macro: LOADER_CHECKSUM_EN
module uart_mem_loader
    import uart_mem_loader_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] LOAD_BASE      = '0,
    parameter int                    MAX_WORDS      = 64,
    parameter int                    TIMEOUT_CYCLES = 100000,
    parameter logic [7:0]            SYNC_BYTE      = SYNC_BYTE_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    uart_mem_loader_if.slave    core,
    uart_mem_loader_if.master   mem,
    output logic                core_hold,
    output logic                load_done,
    output logic                load_error
);
    localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

    state_t                state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [15:0]           word_cnt_q, word_cnt_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [31:0]           word_q, word_d;
    logic [1:0]            we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wd_q, wd_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            sum_q, sum_d;
`endif

    logic        active;
    logic        expired;
    logic [15:0] len_new;
    logic [31:0] word_next;

    assign active    = (state_q == ST_LEN0) || (state_q == ST_LEN1) ||
                       (state_q == ST_DATA) || (state_q == ST_CHK);
    assign len_new   = {rx_data, len_q[7:0]};
    assign word_next = {rx_data, word_q[31:8]};

    loader_timeout_ctr #(
        .TERMINAL (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (rx_valid || (state_d != state_q) || !active),
        .enable  (active),
        .expired (expired)
    );

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        we_d       = WE_NONE;
        addr_d     = addr_q;
        wd_d       = wd_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d      = sum_q;
`endif
        // A write cycle while still in DATA means more words follow; the last
        // word leaves DATA on its 4th byte, so the address never passes the
        // final word slot.
        if (we_q == WE_WORD && state_q == ST_DATA) begin
            addr_d = addr_q + ADDR_WIDTH'(4);
        end

        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (rx_valid && rx_data == SYNC_BYTE) begin
                    state_d    = ST_LEN0;
                    addr_d     = LOAD_BASE;
                    word_cnt_d = '0;
                    byte_cnt_d = '0;
`ifdef LOADER_CHECKSUM_EN
                    sum_d      = '0;
`endif
                end
            end
            ST_LEN0: begin
                if (rx_valid) begin
                    len_d   = {8'h00, rx_data};
                    state_d = ST_LEN1;
                end else if (expired) begin
                    state_d = ST_ERR;
                end
            end
            ST_LEN1: begin
                if (rx_valid) begin
                    len_d = len_new;
                    if (len_new == 16'd0)       state_d = ST_DONE;
                    else if (len_new > MAX_N)   state_d = ST_ERR;
                    else                        state_d = ST_DATA;
                end else if (expired) begin
                    state_d = ST_ERR;
                end
            end
            ST_DATA: begin
                if (rx_valid) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    word_d     = word_next;
`ifdef LOADER_CHECKSUM_EN
                    sum_d      = sum_q + rx_data;
`endif
                    if (byte_cnt_q == 2'd3) begin
                        we_d       = WE_WORD;
                        wd_d       = word_next;
                        word_cnt_d = word_cnt_q + 16'd1;
                        if (word_cnt_q + 16'd1 == len_q) begin
`ifdef LOADER_CHECKSUM_EN
                            state_d = ST_CHK;
`else
                            state_d = ST_DONE;
`endif
                        end
                    end
                end else if (expired) begin
                    state_d = ST_ERR;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (rx_valid) begin
                    state_d = (rx_data == sum_q) ? ST_DONE : ST_ERR;
                end else if (expired) begin
                    state_d = ST_ERR;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            word_q     <= '0;
            we_q       <= WE_NONE;
            addr_q     <= LOAD_BASE;
            wd_q       <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wd_q       <= wd_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    // The final word's write cycle happens after DONE is entered, so the
    // loader keeps the port until that write has been issued.
    assign core_hold  = (state_q != ST_DONE) || (we_q == WE_WORD);
    assign load_done  = (state_q == ST_DONE) && (we_q == WE_NONE);
    assign load_error = (state_q == ST_ERR);

    assign mem.we   = core_hold ? we_q   : core.we;
    assign mem.addr = core_hold ? addr_q : core.addr;
    assign mem.wd   = core_hold ? wd_q   : core.wd;
endmodule

// File: tb/tb_uart_mem_loader.sv
// Directed testbench for uart_mem_loader. Build with +define+LOADER_CHECKSUM_EN
// to exercise the checksum variant; the frames then carry their sum byte.
module tb_uart_mem_loader;
    localparam int TMO = 40;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       core_hold, load_done, load_error;

    uart_mem_loader_if #(.ADDR_WIDTH(32)) core_if ();
    uart_mem_loader_if #(.ADDR_WIDTH(32)) mem_if ();

    uart_mem_loader #(
        .ADDR_WIDTH     (32),
        .LOAD_BASE      (32'h0),
        .MAX_WORDS      (64),
        .TIMEOUT_CYCLES (TMO),
        .SYNC_BYTE      (8'hA5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .core       (core_if),
        .mem        (mem_if),
        .core_hold  (core_hold),
        .load_done  (load_done),
        .load_error (load_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        else             n_pass++;
    endtask

    // Loader writes seen on the Memory port
    logic [31:0] wr_addr [0:127];
    logic [31:0] wr_data [0:127];
    int          wr_cnt = 0;

    always @(negedge clk) begin
        if (rst_n && core_hold && mem_if.we == 2'b01) begin
            wr_addr[wr_cnt[6:0]] <= mem_if.addr;
            wr_data[wr_cnt[6:0]] <= mem_if.wd;
            wr_cnt               <= wr_cnt + 1;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    // Back-to-back bytes start, start+1, ... one per clock
    task automatic send_burst(input int start, input int n);
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) begin
            rx_data  = 8'(start + i);
            rx_valid = 1'b1;
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [7:0] f2 [0:10] = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                              8'h55, 8'h66, 8'h77, 8'h88};
    int base;

    initial begin
        rst_n        = 1'b0;
        rx_data      = 8'h00;
        rx_valid     = 1'b0;
        core_if.we   = 2'b01;
        core_if.addr = 32'h10;
        core_if.wd   = 32'h1234;
        idle(3);
        rst_n = 1'b1;
        idle(2);

        // 1: reset state, core write blocked
        check("rst_core_hold", 32'(core_hold), 32'd1);
        check("rst_load_done", 32'(load_done), 32'd0);
        check("rst_load_error", 32'(load_error), 32'd0);
        check("rst_mem_we", 32'(mem_if.we), 32'd0);
        check("rst_mem_addr", mem_if.addr, 32'h0);
        check("rst_mem_wd", mem_if.wd, 32'h0);
        core_if.we = 2'b00;

        // 2: two-word frame with gaps between bytes
        base = wr_cnt;
        for (int i = 0; i < 11; i++) send_byte(f2[i]);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h64);
`endif
        idle(3);
        check("f2_wr_count", 32'(wr_cnt - base), 32'd2);
        check("f2_addr0", wr_addr[base], 32'h0);
        check("f2_data0", wr_data[base], 32'h44332211);
        check("f2_addr1", wr_addr[base + 1], 32'h4);
        check("f2_data1", wr_data[base + 1], 32'h88776655);
        check("f2_done", 32'(load_done), 32'd1);
        check("f2_hold", 32'(core_hold), 32'd0);
        check("f2_error", 32'(load_error), 32'd0);

        // 3: core passes straight through while released
        core_if.we   = 2'b11;
        core_if.addr = 32'h10;
        core_if.wd   = 32'hAB;
        #1;
        check("pass_we", 32'(mem_if.we), 32'd3);
        check("pass_addr", mem_if.addr, 32'h10);
        check("pass_wd", mem_if.wd, 32'hAB);
        core_if.we = 2'b00;

        // 4: oversize length aborts, then an empty frame completes
        base = wr_cnt;
        send_byte(8'hA5); send_byte(8'h41); send_byte(8'h00);
        idle(2);
        check("len65_error", 32'(load_error), 32'd1);
        check("len65_done", 32'(load_done), 32'd0);
        check("len65_hold", 32'(core_hold), 32'd1);
        check("len65_no_wr", 32'(wr_cnt - base), 32'd0);
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
        idle(2);
        check("len0_done", 32'(load_done), 32'd1);
        check("len0_error", 32'(load_error), 32'd0);
        check("len0_hold", 32'(core_hold), 32'd0);

        // Back-to-back payload: 5th byte lands on the first word's write cycle
        base = wr_cnt;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
        send_burst(1, 8);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h24);
`endif
        idle(3);
        check("b2b_wr_count", 32'(wr_cnt - base), 32'd2);
        check("b2b_data0", wr_data[base], 32'h04030201);
        check("b2b_addr1", wr_addr[base + 1], 32'h4);
        check("b2b_data1", wr_data[base + 1], 32'h08070605);
        check("b2b_done", 32'(load_done), 32'd1);

        // MAX_WORDS frame: fills the whole Memory, last word at 0xFC
        base = wr_cnt;
        send_byte(8'hA5); send_byte(8'h40); send_byte(8'h00);
        send_burst(0, 256);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h80);
`endif
        idle(3);
        check("max_wr_count", 32'(wr_cnt - base), 32'd64);
        check("max_last_addr", wr_addr[(base + 63) % 128], 32'hFC);
        check("max_last_data", wr_data[(base + 63) % 128], 32'hFFFEFDFC);
        check("max_done", 32'(load_done), 32'd1);

        // 5: partial word then silence -> timeout
        base = wr_cnt;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22);
        idle(2);
        check("tmo_pending_error", 32'(load_error), 32'd0);
        idle(TMO + 5);
        check("tmo_error", 32'(load_error), 32'd1);
        check("tmo_hold", 32'(core_hold), 32'd1);
        check("tmo_no_wr", 32'(wr_cnt - base), 32'd0);

        // Async reset mid-frame discards partial state
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h11);
        #2 rst_n = 1'b0;
        #1;
        check("arst_error", 32'(load_error), 32'd0);
        check("arst_hold", 32'(core_hold), 32'd1);
        check("arst_we", 32'(mem_if.we), 32'd0);
        idle(2);
        rst_n = 1'b1;
        base = wr_cnt;
        send_byte(8'h22); send_byte(8'h33); send_byte(8'h44); send_byte(8'h55);
        idle(3);
        check("arst_no_wr", 32'(wr_cnt - base), 32'd0);
        check("arst_done", 32'(load_done), 32'd0);

`ifdef LOADER_CHECKSUM_EN
        // 6: checksum match and mismatch
        base = wr_cnt;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_burst(1, 4);
        send_byte(8'h0A);
        idle(2);
        check("chk_ok_done", 32'(load_done), 32'd1);
        check("chk_ok_data", wr_data[base], 32'h04030201);
        base = wr_cnt;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_burst(1, 4);
        send_byte(8'h0B);
        idle(2);
        check("chk_bad_error", 32'(load_error), 32'd1);
        check("chk_bad_done", 32'(load_done), 32'd0);
        check("chk_bad_wr_kept", 32'(wr_cnt - base), 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
